// File: rtl/reset_sequencer.sv
// reset_sequencer: orders the release of NUM_STAGES active-low reset domains.
// The sequence is ASSERT (hold all domains in reset for at least HOLD_CYC
// cycles), WAIT_LOCK (wait for a stable PLL lock), RELEASE (release domain k
// STAGE_DLY cycles after domain k-1) and RUN. A system reset request, loss of
// PLL lock or a software request sends the block back to ASSERT and records
// the winning cause.
//
// Optional feature macro: RESET_SEQUENCER_LOCK_TMO_EN
//   When defined, WAIT_LOCK gives up after 1024 cycles, raises the sticky
//   lock_fault output and releases the domains anyway.
module reset_sequencer #(
  parameter int unsigned NUM_STAGES = 4,   // 1..8 reset domains
  parameter int unsigned HOLD_CYC   = 32,  // 1..255 minimum ASSERT length
  parameter int unsigned STAGE_DLY  = 16   // 1..255 cycles between releases
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  system_reset_n,
  input  logic                  pll_lock,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] rst_n_out,
  output logic                  seq_done,
  output logic                  sw_reset_ack,
  output logic [1:0]            rst_cause
`ifdef RESET_SEQUENCER_LOCK_TMO_EN
  ,
  output logic                  lock_fault
`endif
);

  typedef enum logic [1:0] {
    ST_ASSERT    = 2'b00,
    ST_WAIT_LOCK = 2'b01,
    ST_RELEASE   = 2'b10,
    ST_RUN       = 2'b11
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_SYS  = 2'b10;
  localparam logic [1:0] CAUSE_LOCK = 2'b11;

  // Terminal values of the 8-bit counters; both counters stop or reload at
  // these values, so they can never wrap.
  localparam logic [7:0] HOLD_TERM  = 8'(HOLD_CYC - 1);
  localparam logic [7:0] STAGE_TERM = 8'(STAGE_DLY - 1);
  localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

  // One-hot mask selecting the domain addressed by a stage index.
  function automatic logic [NUM_STAGES-1:0] stage_bit(input logic [2:0] idx);
    logic [NUM_STAGES-1:0] mask;
    mask = '0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      mask[k] = (3'(k) == idx);
    end
    return mask;
  endfunction

  // ---------------------------------------------------------------------
  // State and next-state signals
  // ---------------------------------------------------------------------
  state_e                state_q,     state_d;
  logic [1:0]            sys_sync_q;
  logic [1:0]            lock_sync_q;
  logic [7:0]            hold_cnt_q,  hold_cnt_d;
  logic [7:0]            stage_cnt_q, stage_cnt_d;
  logic [2:0]            stage_idx_q, stage_idx_d;
  logic [NUM_STAGES-1:0] rel_q,       rel_d;
  logic                  lock_seen_q, lock_seen_d;
  logic [1:0]            cause_q,     cause_d;
  logic                  ack_q,       ack_d;
  logic                  done_q,      done_d;

  logic                  sys_s;
  logic                  lock_s;
  logic                  lock_gate_s;
  logic                  evt_lock_s;
  logic                  evt_sys_s;
  logic                  evt_sw_s;
  logic                  evt_any_s;
  logic [1:0]            evt_cause_s;

`ifdef RESET_SEQUENCER_LOCK_TMO_EN
  logic [9:0]            tmo_cnt_q,   tmo_cnt_d;
  logic                  fault_q,     fault_d;
  logic                  gate_q,      gate_d;

  // Lock-loss is only meaningful after lock was actually acquired; after a
  // timeout exit the domains run without a lock, so a low lock is not an event.
  assign lock_gate_s = gate_q;
  assign lock_fault  = fault_q;
`else
  assign lock_gate_s = 1'b1;
`endif

  assign sys_s  = sys_sync_q[1];
  assign lock_s = lock_sync_q[1];

  // Two-flop synchronizers for the asynchronous system reset and lock inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sys_sync_q  <= 2'b00;
      lock_sync_q <= 2'b00;
    end else begin
      sys_sync_q  <= {sys_sync_q[0], system_reset_n};
      lock_sync_q <= {lock_sync_q[0], pll_lock};
    end
  end

  // Reset-event detection with lock-loss > system > software priority.
  always_comb begin
    evt_lock_s  = 1'b0;
    evt_sys_s   = 1'b0;
    evt_sw_s    = 1'b0;
    evt_any_s   = 1'b0;
    evt_cause_s = CAUSE_POR;
    if ((state_q == ST_RELEASE) || (state_q == ST_RUN)) begin
      evt_lock_s = lock_gate_s & ~lock_s;
    end else begin
      evt_lock_s = 1'b0;
    end
    if (state_q != ST_ASSERT) begin
      evt_sys_s = ~sys_s;
    end else begin
      evt_sys_s = 1'b0;
    end
    if (state_q == ST_RUN) begin
      evt_sw_s = sw_reset_req;
    end else begin
      evt_sw_s = 1'b0;
    end
    evt_any_s = evt_lock_s | evt_sys_s | evt_sw_s;
    if (evt_lock_s) begin
      evt_cause_s = CAUSE_LOCK;
    end else if (evt_sys_s) begin
      evt_cause_s = CAUSE_SYS;
    end else if (evt_sw_s) begin
      evt_cause_s = CAUSE_SW;
    end else begin
      evt_cause_s = CAUSE_POR;
    end
  end

  // Next-state, counter and output-register logic of the sequencing FSM.
  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    stage_cnt_d = stage_cnt_q;
    stage_idx_d = stage_idx_q;
    rel_d       = rel_q;
    cause_d     = cause_q;
    ack_d       = 1'b0;
    lock_seen_d = 1'b0;
`ifdef RESET_SEQUENCER_LOCK_TMO_EN
    tmo_cnt_d   = 10'd0;
    fault_d     = fault_q;
    gate_d      = gate_q;
`endif

    if (evt_any_s) begin
      // Every domain drops on the same edge that enters ASSERT.
      state_d     = ST_ASSERT;
      rel_d       = '0;
      hold_cnt_d  = 8'd0;
      stage_cnt_d = 8'd0;
      stage_idx_d = 3'd0;
      cause_d     = evt_cause_s;
      ack_d       = (evt_cause_s == CAUSE_SW);
    end else begin
      case (state_q)
        ST_ASSERT: begin
          rel_d = '0;
          if (hold_cnt_q == HOLD_TERM) begin
            // Counter parks at terminal until the system request goes away.
            if (sys_s) begin
              state_d    = ST_WAIT_LOCK;
              hold_cnt_d = 8'd0;
            end else begin
              hold_cnt_d = hold_cnt_q;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 8'd1;
          end
        end

        ST_WAIT_LOCK: begin
          lock_seen_d = lock_s;
          if (lock_s && lock_seen_q) begin
            state_d     = ST_RELEASE;
            stage_cnt_d = 8'd0;
            stage_idx_d = 3'd0;
`ifdef RESET_SEQUENCER_LOCK_TMO_EN
            gate_d      = 1'b1;
          end else if (tmo_cnt_q == 10'd1023) begin
            state_d     = ST_RELEASE;
            stage_cnt_d = 8'd0;
            stage_idx_d = 3'd0;
            fault_d     = 1'b1;
            gate_d      = 1'b0;
          end else begin
            tmo_cnt_d   = tmo_cnt_q + 10'd1;
`else
          end else begin
            state_d     = ST_WAIT_LOCK;
`endif
          end
        end

        ST_RELEASE: begin
          if (stage_cnt_q == STAGE_TERM) begin
            stage_cnt_d = 8'd0;
            rel_d       = rel_q | stage_bit(stage_idx_q);
            if (stage_idx_q == LAST_STAGE) begin
              state_d = ST_RUN;
            end else begin
              stage_idx_d = stage_idx_q + 3'd1;
            end
          end else begin
            stage_cnt_d = stage_cnt_q + 8'd1;
          end
        end

        ST_RUN: begin
          state_d = ST_RUN;
        end

        default: begin
          state_d = ST_ASSERT;
          rel_d   = '0;
        end
      endcase
    end

    done_d = (state_d == ST_RUN);
  end

  // FSM, counters and registered outputs; rstn forces every domain into reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_ASSERT;
      hold_cnt_q  <= 8'd0;
      stage_cnt_q <= 8'd0;
      stage_idx_q <= 3'd0;
      rel_q       <= '0;
      lock_seen_q <= 1'b0;
      cause_q     <= CAUSE_POR;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      stage_cnt_q <= stage_cnt_d;
      stage_idx_q <= stage_idx_d;
      rel_q       <= rel_d;
      lock_seen_q <= lock_seen_d;
      cause_q     <= cause_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
    end
  end

`ifdef RESET_SEQUENCER_LOCK_TMO_EN
  // Lock timeout counter, sticky fault flag and lock-loss qualifier.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_q <= 10'd0;
      fault_q   <= 1'b0;
      gate_q    <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      fault_q   <= fault_d;
      gate_q    <= gate_d;
    end
  end
`endif

  assign rst_n_out    = rel_q;
  assign seq_done     = done_q;
  assign sw_reset_ack = ack_q;
  assign rst_cause    = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer with NUM_STAGES=3, HOLD_CYC=8,
// STAGE_DLY=4. A table of input phases is applied; each phase pushes its
// expected outputs to a scoreboard queue that is popped when the phase ends.
// Hand-written sequences cover asynchronous rstn and the no-lock case.
module tb_reset_sequencer;

  localparam int NS = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic          system_reset_n;
  logic          pll_lock;
  logic          sw_reset_req;
  logic [NS-1:0] rst_n_out;
  logic          seq_done;
  logic          sw_reset_ack;
  logic [1:0]    rst_cause;
`ifdef RESET_SEQUENCER_LOCK_TMO_EN
  logic          lock_fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic       rstn;
    logic       sys;
    logic       lock;
    logic       sw;
    int         cyc;
    logic [2:0] rst;
    logic       done;
    logic       ack;
    logic [1:0] cause;
  } vec_t;

  vec_t       vq[$];
  logic [6:0] exp_q[$];

  reset_sequencer #(
    .NUM_STAGES(NS),
    .HOLD_CYC  (8),
    .STAGE_DLY (4)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .system_reset_n(system_reset_n),
    .pll_lock      (pll_lock),
    .sw_reset_req  (sw_reset_req),
    .rst_n_out     (rst_n_out),
    .seq_done      (seq_done),
    .sw_reset_ack  (sw_reset_ack),
    .rst_cause     (rst_cause)
`ifdef RESET_SEQUENCER_LOCK_TMO_EN
    ,
    .lock_fault    (lock_fault)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] obs();
    return {rst_n_out, seq_done, sw_reset_ack, rst_cause};
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got rst_n_out=%b done=%b ack=%b cause=%b, expected rst_n_out=%b done=%b ack=%b cause=%b",
               name, act[6:4], act[3], act[2], act[1:0], exp[6:4], exp[3], exp[2], exp[1:0]);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic r, input logic s, input logic l, input logic w, input int c,
                         input logic [2:0] er, input logic ed, input logic ea, input logic [1:0] ec);
    vec_t v;
    v.rstn = r; v.sys = s; v.lock = l; v.sw = w; v.cyc = c;
    v.rst = er; v.done = ed; v.ack = ea; v.cause = ec;
    vq.push_back(v);
  endtask

  // Steps until rst_n_out equals target; returns step count or -1 on timeout.
  task automatic wait_rst(input logic [2:0] target, input int bound, output int n);
    n = -1;
    for (int i = 1; i <= bound; i++) begin
      step();
      if (rst_n_out == target) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before end of test");
    $fatal(1, "time limit");
  end

  initial begin
    int   n;
    logic any_rel;
    logic [6:0] e;

    rstn = 1'b0; system_reset_n = 1'b1; pll_lock = 1'b1; sw_reset_req = 1'b0;

    //       rstn  sys   lock  sw   cyc  rst     done  ack   cause
    // power-on: release after 8 hold + 2 lock cycles, then 4-cycle spacing
    add_vec(1'b0, 1'b1, 1'b1, 1'b0,  3, 3'b000, 1'b0, 1'b0, 2'b00);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0, 13, 3'b000, 1'b0, 1'b0, 2'b00);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  1, 3'b001, 1'b0, 1'b0, 2'b00);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  3, 3'b001, 1'b0, 1'b0, 2'b00);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  1, 3'b011, 1'b0, 1'b0, 2'b00);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  3, 3'b011, 1'b0, 1'b0, 2'b00);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  1, 3'b111, 1'b1, 1'b0, 2'b00);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  5, 3'b111, 1'b1, 1'b0, 2'b00);
    // software reset; request held into ASSERT gives no second ack
    add_vec(1'b1, 1'b1, 1'b1, 1'b1,  1, 3'b000, 1'b0, 1'b1, 2'b01);
    add_vec(1'b1, 1'b1, 1'b1, 1'b1,  1, 3'b000, 1'b0, 1'b0, 2'b01);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0, 12, 3'b000, 1'b0, 1'b0, 2'b01);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  1, 3'b001, 1'b0, 1'b0, 2'b01);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  8, 3'b111, 1'b1, 1'b0, 2'b01);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  4, 3'b111, 1'b1, 1'b0, 2'b01);
    // lock and system fall together: 2-cycle sync, lock-loss wins
    add_vec(1'b1, 1'b0, 1'b0, 1'b0,  2, 3'b111, 1'b1, 1'b0, 2'b01);
    add_vec(1'b1, 1'b0, 1'b0, 1'b0,  1, 3'b000, 1'b0, 1'b0, 2'b11);
    add_vec(1'b1, 1'b0, 1'b1, 1'b0, 50, 3'b000, 1'b0, 1'b0, 2'b11);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  8, 3'b000, 1'b0, 1'b0, 2'b11);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  1, 3'b001, 1'b0, 1'b0, 2'b11);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  8, 3'b111, 1'b1, 1'b0, 2'b11);
    // system and software in the same cycle: system wins, no ack
    add_vec(1'b1, 1'b0, 1'b1, 1'b0,  2, 3'b111, 1'b1, 1'b0, 2'b11);
    add_vec(1'b1, 1'b0, 1'b1, 1'b1,  1, 3'b000, 1'b0, 1'b0, 2'b10);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0, 13, 3'b000, 1'b0, 1'b0, 2'b10);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  1, 3'b001, 1'b0, 1'b0, 2'b10);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  8, 3'b111, 1'b1, 1'b0, 2'b10);
    // lock loss alone
    add_vec(1'b1, 1'b1, 1'b0, 1'b0,  2, 3'b111, 1'b1, 1'b0, 2'b10);
    add_vec(1'b1, 1'b1, 1'b0, 1'b0,  1, 3'b000, 1'b0, 1'b0, 2'b11);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0, 13, 3'b000, 1'b0, 1'b0, 2'b11);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  1, 3'b001, 1'b0, 1'b0, 2'b11);
    add_vec(1'b1, 1'b1, 1'b1, 1'b0,  8, 3'b111, 1'b1, 1'b0, 2'b11);

    foreach (vq[i]) begin
      rstn           = vq[i].rstn;
      system_reset_n = vq[i].sys;
      pll_lock       = vq[i].lock;
      sw_reset_req   = vq[i].sw;
      exp_q.push_back({vq[i].rst, vq[i].done, vq[i].ack, vq[i].cause});
      repeat (vq[i].cyc) step();
      e = exp_q.pop_front();
      check($sformatf("vec%0d", i), obs(), e);
    end

    // rstn pulse in the middle of RELEASE
    sw_reset_req = 1'b1;
    step();
    sw_reset_req = 1'b0;
    check("sw_ack_before_rstn", obs(), {3'b000, 1'b0, 1'b1, 2'b01});
    wait_rst(3'b001, 40, n);
    check_int("sw_first_stage_cycles", n, 14);
    #3;
    rstn = 1'b0;
    #1;
    check("rstn_async_drop", obs(), {3'b000, 1'b0, 1'b0, 2'b00});
    step();
    step();
    check("rstn_held", obs(), {3'b000, 1'b0, 1'b0, 2'b00});
    rstn = 1'b1;
    wait_rst(3'b001, 40, n);
    check_int("restart_first_stage_cycles", n, 14);
    wait_rst(3'b011, 10, n);
    check_int("restart_stage1_spacing", n, 4);
    wait_rst(3'b111, 10, n);
    check_int("restart_stage2_spacing", n, 4);
    check("restart_run", obs(), {3'b111, 1'b1, 1'b0, 2'b00});

    // PLL never locks after power-on
    pll_lock = 1'b0;
    rstn     = 1'b0;
    step();
    rstn = 1'b1;
`ifdef RESET_SEQUENCER_LOCK_TMO_EN
    n = -1;
    for (int i = 1; i <= 1100; i++) begin
      step();
      if (lock_fault) begin
        n = i;
        break;
      end
    end
    check_int("lock_timeout_cycles", n, 1032);
    repeat (12) step();
    check("lock_timeout_release", obs(), {3'b111, 1'b1, 1'b0, 2'b00});
    check_int("lock_fault_sticky", int'(lock_fault), 1);
`else
    any_rel = 1'b0;
    for (int i = 1; i <= 1100; i++) begin
      step();
      if (i == 100) begin
        sw_reset_req = 1'b1;
      end else begin
        sw_reset_req = 1'b0;
      end
      if ((rst_n_out != 3'b000) || seq_done || sw_reset_ack) begin
        any_rel = 1'b1;
      end
    end
    check_int("no_lock_stays_reset", int'(any_rel), 0);
    check("no_lock_final", obs(), {3'b000, 1'b0, 1'b0, 2'b00});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
